// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w3_pkg.sv
// Shared constants for the gate1 IJTAG data-mux override controller:
// FSM encodings, TDR field positions and default timing parameters.
package firebird7_in_gate1_tessent_data_mux_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  localparam int DEF_DATA_WIDTH    = 3;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_ACK_TIMEOUT   = 255;
  localparam int DEF_CNT_WIDTH     = 8;

  // TDR layout: {override_en, err_clr, data[dw-1:0]}
  function automatic int tdr_width(input int dw);
    return dw + 2;
  endfunction

  function automatic int idx_override_en(input int dw);
    return dw + 1;
  endfunction

  function automatic int idx_err_clr(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w3_if.sv
// IJTAG TDR access plus data-mux / functional-owner handshake bundle.
// master = network/bench side, slave = controller side.
interface firebird7_in_gate1_tessent_data_mux_ctrl_w3_if #(
  parameter int DATA_WIDTH = 3
);
  logic                  ijtag_sel;
  logic                  ijtag_se;
  logic                  ijtag_ce;
  logic                  ijtag_ue;
  logic                  ijtag_si;
  logic                  ijtag_so;
  logic [DATA_WIDTH-1:0] functional_data_in;
  logic                  quiesce_ack;
  logic                  quiesce_req;
  logic                  ijtag_select;
  logic [DATA_WIDTH-1:0] ijtag_data_out;
  logic                  override_active;
  logic                  timeout_err;

  modport master (
    output ijtag_sel, ijtag_se, ijtag_ce, ijtag_ue, ijtag_si,
    output functional_data_in, quiesce_ack,
    input  ijtag_so, quiesce_req, ijtag_select, ijtag_data_out,
    input  override_active, timeout_err
  );

  modport slave (
    input  ijtag_sel, ijtag_se, ijtag_ce, ijtag_ue, ijtag_si,
    input  functional_data_in, quiesce_ack,
    output ijtag_so, quiesce_req, ijtag_select, ijtag_data_out,
    output override_active, timeout_err
  );

endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w3_tdr_csu.sv
// Generic IJTAG capture/shift/update data register, LSB-first scan out.
// Capture beats shift beats update when several enables are high together.
module firebird7_in_gate1_tessent_tdr_csu #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sel,
  input  logic             i_ce,
  input  logic             i_se,
  input  logic             i_ue,
  input  logic             i_si,
  input  logic [WIDTH-1:0] i_capture,
  output logic             o_so,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_upd,
  output logic [WIDTH-1:0] o_upd_data
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_shadow;
  logic             w_cap;
  logic             w_shf;
  logic             w_upd;

  assign w_cap = i_sel & i_ce;
  assign w_shf = i_sel & i_se & ~i_ce;
  assign w_upd = i_sel & i_ue & ~i_ce & ~i_se;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift  <= '0;
      r_shadow <= '0;
    end else begin
      if (w_cap) begin
        r_shift <= i_capture;
      end else if (w_shf) begin
        r_shift <= {i_si, r_shift[WIDTH-1:1]};
      end
      if (w_upd) begin
        r_shadow <= r_shift;
      end
    end
  end

  assign o_so       = r_shift[0];
  assign o_shadow   = r_shadow;
  assign o_upd      = w_upd;
  assign o_upd_data = r_shift;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w3.sv
// Safe-takeover controller for the ijtag side of a 3-bit IJTAG data mux.
//   state  | meaning
//   IDLE   | functional owner drives the mux, no request outstanding
//   REQ    | quiesce_req raised, waiting for quiesce_ack (bounded)
//   SETTLE | owner frozen, waiting SETTLE_CYCLES before switching the mux
//   ACTIVE | mux selected, override data driven
//   DRAIN  | mux released, holding quiesce_req SETTLE_CYCLES more
module firebird7_in_gate1_tessent_data_mux_ctrl_w3
  import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input logic ijtag_tck,
  input logic ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_ctrl_w3_if.slave bus
);

  localparam int TDR_W   = tdr_width(DATA_WIDTH);
  localparam int IDX_OVR = idx_override_en(DATA_WIDTH);
  localparam int IDX_CLR = idx_err_clr(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ACK_LAST    = CNT_WIDTH'(ACK_TIMEOUT);

  logic [TDR_W-1:0]      w_shadow;
  logic [TDR_W-1:0]      w_upd_data;
  logic [TDR_W-1:0]      w_capture;
  logic                  w_upd;
  logic                  w_override_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_unused;

  logic [2:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_retry_blk;
  logic                  r_timeout_err;
  logic                  r_quiesce_req;
  logic                  r_select;
  logic                  r_override_active;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic [2:0]            w_state_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_to_hit;

  assign w_capture = {r_override_active, r_timeout_err, bus.functional_data_in};

  firebird7_in_gate1_tessent_tdr_csu #(
    .WIDTH (TDR_W)
  ) u_tdr (
    .i_clk      (ijtag_tck),
    .i_rst      (ijtag_reset),
    .i_sel      (bus.ijtag_sel),
    .i_ce       (bus.ijtag_ce),
    .i_se       (bus.ijtag_se),
    .i_ue       (bus.ijtag_ue),
    .i_si       (bus.ijtag_si),
    .i_capture  (w_capture),
    .o_so       (bus.ijtag_so),
    .o_shadow   (w_shadow),
    .o_upd      (w_upd),
    .o_upd_data (w_upd_data)
  );

  assign w_override_en = w_shadow[IDX_OVR];
  assign w_data        = w_shadow[DATA_WIDTH-1:0];
  // err_clr acts as a strobe at update time; its shadow copy has no further use
  assign w_unused      = ^{w_shadow[IDX_CLR], w_upd_data};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_hit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_override_en && !r_retry_blk) begin
          w_state_nxt = ST_REQ;
          w_cnt_nxt   = '0;
        end
      end
      ST_REQ: begin
        if (bus.quiesce_ack) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end else if (!w_override_en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == ACK_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_to_hit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!w_override_en) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!w_override_en) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so the mux select never glitches.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_state           <= ST_IDLE;
      r_cnt             <= '0;
      r_retry_blk       <= 1'b0;
      r_timeout_err     <= 1'b0;
      r_quiesce_req     <= 1'b0;
      r_select          <= 1'b0;
      r_override_active <= 1'b0;
      r_data_out        <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_cnt             <= w_cnt_nxt;
      r_quiesce_req     <= (w_state_nxt != ST_IDLE);
      r_select          <= (w_state_nxt == ST_ACTIVE);
      r_override_active <= (w_state_nxt == ST_ACTIVE);
      r_data_out        <= (w_state_nxt == ST_ACTIVE) ? w_data : '0;
      // a timed-out request stays parked until software drops override_en
      if (w_to_hit) begin
        r_retry_blk <= 1'b1;
      end else if (!w_override_en) begin
        r_retry_blk <= 1'b0;
      end
      if (w_to_hit) begin
        r_timeout_err <= 1'b1;
      end else if (w_upd && w_upd_data[IDX_CLR]) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign bus.quiesce_req     = r_quiesce_req;
  assign bus.ijtag_select    = r_select;
  assign bus.ijtag_data_out  = r_data_out;
  assign bus.override_active = r_override_active;
  assign bus.timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w3.sv
// Directed bench for the data-mux override controller (ACK_TIMEOUT=8).
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [4:0] rd;

  firebird7_in_gate1_tessent_data_mux_ctrl_w3_if #(.DATA_WIDTH(3)) bus ();

  firebird7_in_gate1_tessent_data_mux_ctrl_w3 #(
    .DATA_WIDTH    (3),
    .SETTLE_CYCLES (4),
    .ACK_TIMEOUT   (8),
    .CNT_WIDTH     (8)
  ) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tdr_write(input logic [4:0] v);
    bus.ijtag_sel = 1'b1;
    bus.ijtag_se  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ijtag_si = v[i];
      tick();
    end
    bus.ijtag_se = 1'b0;
    bus.ijtag_ue = 1'b1;
    tick();
    bus.ijtag_ue  = 1'b0;
    bus.ijtag_sel = 1'b0;
    bus.ijtag_si  = 1'b0;
  endtask

  task automatic tdr_read(output logic [4:0] v);
    bus.ijtag_sel = 1'b1;
    bus.ijtag_ce  = 1'b1;
    tick();
    bus.ijtag_ce = 1'b0;
    bus.ijtag_se = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v[i] = bus.ijtag_so;
      tick();
    end
    bus.ijtag_se  = 1'b0;
    bus.ijtag_sel = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.ijtag_sel = 1'b0;
    bus.ijtag_se  = 1'b0;
    bus.ijtag_ce  = 1'b0;
    bus.ijtag_ue  = 1'b0;
    bus.ijtag_si  = 1'b0;
    bus.functional_data_in = 3'b110;
    bus.quiesce_ack = 1'b0;

    // reset and idle
    tick();
    tick();
    chk("rst_outs", {2'b0, bus.ijtag_so, bus.quiesce_req, bus.ijtag_select,
                     bus.override_active, bus.timeout_err, 1'b0}, 8'h00);
    chk("rst_data", {5'b0, bus.ijtag_data_out}, 8'h00);
    rst = 1'b0;
    tick();
    tdr_read(rd);
    chk("idle_capture", {3'b0, rd}, 8'h06);

    // normal takeover: en=1 data=101
    tdr_write(5'b10101);
    chk("req_not_yet", {7'b0, bus.quiesce_req}, 8'h00);
    tick();
    chk("req_rise", {7'b0, bus.quiesce_req}, 8'h01);
    tick();
    tick();
    bus.quiesce_ack = 1'b1;
    tick();
    chk("settle_sel0", {6'b0, bus.quiesce_req, bus.ijtag_select}, 8'h02);
    tick();
    tick();
    tick();
    chk("settle_end_sel0", {7'b0, bus.ijtag_select}, 8'h00);
    tick();
    chk("active_sel", {6'b0, bus.ijtag_select, bus.override_active}, 8'h03);
    chk("active_data", {5'b0, bus.ijtag_data_out}, 8'h05);

    // ack drop ignored, live data change
    bus.quiesce_ack = 1'b0;
    tick();
    chk("ack_drop_hold", {7'b0, bus.ijtag_select}, 8'h01);
    tdr_write(5'b10010);
    chk("data_old", {5'b0, bus.ijtag_data_out}, 8'h05);
    tick();
    chk("data_new", {5'b0, bus.ijtag_data_out}, 8'h02);

    // release through DRAIN
    tdr_write(5'b00010);
    chk("rel_sel_hold", {7'b0, bus.ijtag_select}, 8'h01);
    tick();
    chk("drain_entry", {3'b0, bus.quiesce_req, bus.ijtag_select, bus.ijtag_data_out}, 8'h10);
    tick();
    tick();
    tick();
    chk("drain_req_held", {7'b0, bus.quiesce_req}, 8'h01);
    tick();
    chk("drain_req_fall", {7'b0, bus.quiesce_req}, 8'h00);

    // timeout after 9 cycles in REQ
    tdr_write(5'b10000);
    tick();
    chk("to_req", {7'b0, bus.quiesce_req}, 8'h01);
    for (int i = 0; i < 8; i++) tick();
    chk("to_edge_minus1", {6'b0, bus.quiesce_req, bus.timeout_err}, 8'h02);
    tick();
    chk("to_fire", {6'b0, bus.quiesce_req, bus.timeout_err}, 8'h01);
    tick();
    tick();
    chk("to_no_retry", {7'b0, bus.quiesce_req}, 8'h00);
    tdr_read(rd);
    chk("to_capture", {3'b0, rd}, 8'h0E);
    tdr_write(5'b01000);
    chk("err_clr", {7'b0, bus.timeout_err}, 8'h00);

    // abort while in REQ
    tdr_write(5'b10000);
    tick();
    chk("abort_req", {7'b0, bus.quiesce_req}, 8'h01);
    tdr_write(5'b00000);
    chk("abort_pre", {6'b0, bus.quiesce_req, bus.ijtag_select}, 8'h02);
    tick();
    chk("abort_done", {5'b0, bus.quiesce_req, bus.ijtag_select, bus.timeout_err}, 8'h00);

    // ack coincident with timeout cycle: ack wins
    tdr_write(5'b10011);
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("race_pre", {6'b0, bus.quiesce_req, bus.timeout_err}, 8'h02);
    bus.quiesce_ack = 1'b1;
    tick();
    chk("race_settle", {5'b0, bus.quiesce_req, bus.ijtag_select, bus.timeout_err}, 8'h04);
    tick();
    tick();
    tick();
    chk("race_settle_end", {7'b0, bus.ijtag_select}, 8'h00);
    tick();
    chk("race_active", {4'b0, bus.ijtag_select, bus.ijtag_data_out}, 8'h0B);

    // mid-operation reset
    rst = 1'b1;
    tick();
    chk("midrst_outs", {3'b0, bus.quiesce_req, bus.ijtag_select, bus.override_active,
                        bus.timeout_err, bus.ijtag_so}, 8'h00);
    chk("midrst_data", {5'b0, bus.ijtag_data_out}, 8'h00);
    rst = 1'b0;
    bus.functional_data_in = 3'b001;
    tick();
    tick();
    chk("midrst_shadow_clr", {7'b0, bus.quiesce_req}, 8'h00);
    tdr_read(rd);
    chk("midrst_capture", {3'b0, rd}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
